// File: rtl/disp_pkg.sv
// Shared constants and helpers for the display source selector.
//   MODE_*     : mode indices of the standard producers.
//   seg_blank  : all-off segment pattern for a given polarity.
//   digit_lsb  : bit offset of (source, digit) inside a flattened display bus.
package disp_pkg;

  localparam int MODE_CLOCK     = 0;
  localparam int MODE_ALARM     = 1;
  localparam int MODE_STOPWATCH = 2;

  localparam int SEG_W_MAX = 32;

  // Every segment bit is driven to the "off" level.
  // With active-low segments the off level is 1.
  function automatic logic [SEG_W_MAX-1:0] seg_blank(input int seg_w, input bit active_low);
    logic [SEG_W_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < SEG_W_MAX; i++) begin
      if (i < seg_w) v[i] = active_low;
    end
    return v;
  endfunction

  function automatic int digit_lsb(input int src, input int digit, input int num_digits,
                                   input int seg_w);
    return (src * num_digits + digit) * seg_w;
  endfunction

endpackage

// File: rtl/disp_blink_gen.sv
// Blink phase generator for the digit edit cursor.
//   clk, reset      : system clock, synchronous active-high reset
//   i_restart       : forces counter = 0 and phase = on (used on mode change)
//   o_blink_phase   : 1 = blinking digits visible, 0 = blanked
// Counter runs 0..BLINK_DIV-1; the phase toggles each time it wraps.
module disp_blink_gen #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_blink_phase
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge clk) begin
    if (reset || i_restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_blink_phase = r_phase;

endmodule

// File: rtl/display_source_mux.sv
// Registered N-way selector driving the six-digit 7-segment bank.
// Owns the display-mode register: a button pulse advances to the next
// implemented source, a load pulse jumps straight to a given source.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   mode_btn      : one-cycle pulse, advance to next valid source
//   mode_load     : one-cycle pulse, load mode_in if it names a valid source
//   mode_in       : target mode for mode_load
//   src_valid     : bit s = source s implemented
//   src_disp      : source s digit d at [(s*NUM_DIGITS+d)*SEG_W +: SEG_W]
//   blink_mask    : bit d = digit d blinks (only with DISP_BLINK_EN)
//   final_disp    : registered segment drive, digit d at [d*SEG_W +: SEG_W]
//   mode          : current mode index
//   mode_changed  : one-cycle pulse, high in the cycle mode shows a new value
// Build option: define DISP_BLINK_EN to enable cursor blinking via blink_mask.
//
// Handshake: no valid/ready pairs here; mode_btn and mode_load are single-cycle
// strobes, each acted on in the cycle it is high. mode_load has priority; a
// rejected load (out of range or invalid source) also drops a simultaneous btn.
import disp_pkg::*;

module display_source_mux #(
  parameter int NUM_SRC        = 3,
  parameter int NUM_DIGITS     = 6,
  parameter int SEG_W          = 7,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_DIV      = 25_000_000,
  localparam int MW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mode_btn,
  input  logic                                mode_load,
  input  logic [MW-1:0]                       mode_in,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC*NUM_DIGITS*SEG_W-1:0] src_disp,
  input  logic [NUM_DIGITS-1:0]               blink_mask,
  output logic [NUM_DIGITS*SEG_W-1:0]         final_disp,
  output logic [MW-1:0]                       mode,
  output logic                                mode_changed
);

  localparam int DW = NUM_DIGITS * SEG_W;
  localparam logic [SEG_W-1:0] BLANK = SEG_W'(seg_blank(SEG_W, SEG_ACTIVE_LOW != 0));

  logic [MW-1:0]         r_mode;
  logic                  r_mode_changed;
  logic [DW-1:0]         r_disp;

  logic                  w_load_ok;
  logic                  w_scan_found;
  logic [MW-1:0]         w_scan_mode;
  logic [MW-1:0]         w_mode_nxt;
  logic                  w_mode_change;
  logic                  w_sel_valid;
  logic [DW-1:0]         w_sel_disp;
  logic [NUM_DIGITS-1:0] w_digit_blank;
  logic [DW-1:0]         w_disp_nxt;

  // Load accepted only for an in-range, implemented source.
  always_comb begin
    w_load_ok = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (mode_in == MW'(s) && src_valid[s]) w_load_ok = 1'b1;
    end
  end

  // Next-valid search: distances NUM_SRC-1 down to 1 so the nearest valid
  // source is the last one written. Wrap is modulo NUM_SRC.
  always_comb begin
    int idx;
    w_scan_found = 1'b0;
    w_scan_mode  = r_mode;
    idx          = 0;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      idx = (int'(r_mode) + k) % NUM_SRC;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (idx == s && src_valid[s]) begin
          w_scan_found = 1'b1;
          w_scan_mode  = MW'(s);
        end
      end
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (mode_load) begin
      if (w_load_ok) w_mode_nxt = mode_in;
    end else if (mode_btn && w_scan_found) begin
      w_mode_nxt = w_scan_mode;
    end
  end

  assign w_mode_change = (w_mode_nxt != r_mode);

  // Source select from the registered mode (no input-to-output comb path).
  always_comb begin
    w_sel_disp  = '0;
    w_sel_valid = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (r_mode == MW'(s)) begin
        w_sel_disp  = src_disp[digit_lsb(s, 0, NUM_DIGITS, SEG_W) +: DW];
        w_sel_valid = src_valid[s];
      end
    end
  end

`ifdef DISP_BLINK_EN
  logic w_blink_phase;

  // Restart on every mode change so a freshly selected screen appears at once.
  disp_blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk          (clk),
    .reset        (reset),
    .i_restart    (w_mode_change),
    .o_blink_phase(w_blink_phase)
  );

  assign w_digit_blank = blink_mask & {NUM_DIGITS{~w_blink_phase}};
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask;
  assign w_digit_blank  = '0;
`endif

  always_comb begin
    w_disp_nxt = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_sel_valid && !w_digit_blank[d]) w_disp_nxt[d*SEG_W +: SEG_W] = w_sel_disp[d*SEG_W +: SEG_W];
      else                                  w_disp_nxt[d*SEG_W +: SEG_W] = BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode         <= MW'(MODE_CLOCK);
      r_mode_changed <= 1'b0;
      r_disp         <= {NUM_DIGITS{BLANK}};
    end else begin
      r_mode         <= w_mode_nxt;
      r_mode_changed <= w_mode_change;
      r_disp         <= w_disp_nxt;
    end
  end

  assign final_disp   = r_disp;
  assign mode         = r_mode;
  assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_display_source_mux.sv
module tb_display_source_mux;

  localparam int NS = 3;
  localparam int ND = 6;
  localparam int SW = 7;
  localparam int BD = 4;
  localparam int MW = 2;
  localparam int DW = ND * SW;
`ifdef DISP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              mode_btn;
  logic              mode_load;
  logic [MW-1:0]     mode_in;
  logic [NS-1:0]     src_valid;
  logic [NS*DW-1:0]  src_disp;
  logic [ND-1:0]     blink_mask;
  logic [DW-1:0]     final_disp;
  logic [MW-1:0]     mode;
  logic              mode_changed;

  always #5 clk = ~clk;

  display_source_mux #(
    .NUM_SRC(NS), .NUM_DIGITS(ND), .SEG_W(SW), .SEG_ACTIVE_LOW(1), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .mode_load(mode_load),
    .mode_in(mode_in), .src_valid(src_valid), .src_disp(src_disp),
    .blink_mask(blink_mask), .final_disp(final_disp), .mode(mode),
    .mode_changed(mode_changed)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [SW-1:0] src_val [NS][ND];

  task automatic pack_src();
    for (int s = 0; s < NS; s++)
      for (int d = 0; d < ND; d++)
        src_disp[(s*ND+d)*SW +: SW] = src_val[s][d];
  endtask

  task automatic default_src();
    for (int s = 0; s < NS; s++)
      for (int d = 0; d < ND; d++)
        src_val[s][d] = SW'(16*s + d);
    pack_src();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mode_btn  = 1'b0;
    mode_load = 1'b0;
  endtask

  function automatic logic [SW-1:0] digit_of(input logic [DW-1:0] v, input int d);
    return v[d*SW +: SW];
  endfunction

  // ---------------- behavioural model ----------------
  // Mode as an integer, blink as a cycle counter; outputs for the next cycle
  // computed from the pre-edge model state and the inputs seen at the edge.
  int            m_mode  = 0;
  bit            m_chg   = 1'b0;
  int            m_cnt   = 0;
  bit            m_phase = 1'b1;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin
    int            nm;
    int            mi;
    logic [DW-1:0] e;
    nm = m_mode;
    e  = '0;
    for (int d = 0; d < ND; d++) begin
      if (!reset && src_valid[m_mode] && !(BLINK_ON && blink_mask[d] && !m_phase))
        e[d*SW +: SW] = src_val[m_mode][d];
      else
        e[d*SW +: SW] = 7'h7F;
    end
    if (reset) begin
      nm = 0;
    end else if (mode_load) begin
      mi = int'(mode_in);
      if (mi < NS) begin
        if (src_valid[mi]) nm = mi;
      end
    end else if (mode_btn) begin
      for (int k = 1; k < NS; k++) begin
        if (nm == m_mode && src_valid[(m_mode + k) % NS]) nm = (m_mode + k) % NS;
      end
    end
    m_chg = !reset && (nm != m_mode);
    if (reset || nm != m_mode) begin
      m_cnt   = 0;
      m_phase = 1'b1;
    end else if (m_cnt == BD - 1) begin
      m_cnt   = 0;
      m_phase = !m_phase;
    end else begin
      m_cnt = m_cnt + 1;
    end
    m_mode = nm;
    exp_q.push_back(e);
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e;
    e = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (chk_en) begin
        check("model_mode", 64'(mode), 64'(m_mode));
        check("model_mode_changed", 64'(mode_changed), 64'(m_chg));
        check("model_final_disp", 64'(final_disp), 64'(e));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [DW-1:0] blank_all;
    blank_all  = {ND{7'h7F}};
    reset      = 1'b1;
    idle_inputs();
    mode_in    = '0;
    src_valid  = 3'b111;
    blink_mask = '0;
    default_src();

    // 1: reset held 3 clocks
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_disp", 64'(final_disp), 64'(blank_all));
    check("rst_mode", 64'(mode), 64'd0);
    check("rst_chg", 64'(mode_changed), 64'd0);
    reset = 1'b0;
    tick();
    tick();
    for (int d = 0; d < ND; d++) check("rel_digit", 64'(digit_of(final_disp, d)), 64'(d));

    // 2: skip invalid source 1, then wrap
    src_valid = 3'b101;
    mode_btn  = 1'b1;
    tick();
    idle_inputs();
    check("skip_mode", 64'(mode), 64'd2);
    check("skip_chg", 64'(mode_changed), 64'd1);
    check("skip_old_data", 64'(digit_of(final_disp, 3)), 64'h03);
    tick();
    check("skip_chg_drop", 64'(mode_changed), 64'd0);
    for (int d = 0; d < ND; d++) check("skip_digit", 64'(digit_of(final_disp, d)), 64'(7'h20 + d));
    mode_btn = 1'b1;
    tick();
    idle_inputs();
    check("wrap_mode", 64'(mode), 64'd0);
    tick();

    // 3: load beats button; out-of-range load ignored; reload of same mode silent
    src_valid = 3'b111;
    mode_btn  = 1'b1; mode_load = 1'b1; mode_in = 2'd1;
    tick();
    idle_inputs();
    check("prio_mode1", 64'(mode), 64'd1);
    mode_btn  = 1'b1; mode_load = 1'b1; mode_in = 2'd0;
    tick();
    idle_inputs();
    check("prio_mode0", 64'(mode), 64'd0);
    tick();
    mode_load = 1'b1; mode_in = 2'd3;
    tick();
    idle_inputs();
    check("oor_mode", 64'(mode), 64'd0);
    check("oor_chg", 64'(mode_changed), 64'd0);
    mode_load = 1'b1; mode_in = 2'd0;
    tick();
    idle_inputs();
    check("same_load_chg", 64'(mode_changed), 64'd0);

    // 4: lone valid source, then it disappears
    src_valid = 3'b001;
    mode_btn  = 1'b1;
    tick();
    idle_inputs();
    check("lone_mode", 64'(mode), 64'd0);
    check("lone_chg", 64'(mode_changed), 64'd0);
    src_valid = 3'b000;
    tick();
    check("drop_blank", 64'(final_disp), 64'(blank_all));
    src_valid = 3'b111;
    tick();

`ifdef DISP_BLINK_EN
    // 5: digit 0 blinks 4 on / 4 off; mode change mid-off shows it at once
    blink_mask = 6'b000001;
    mode_load  = 1'b1; mode_in = 2'd1;
    tick();
    idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("blink_d0", 64'(digit_of(final_disp, 0)), (k <= 4) ? 64'h10 : 64'h7F);
      check("blink_d1", 64'(digit_of(final_disp, 1)), 64'h11);
    end
    mode_load = 1'b1; mode_in = 2'd2;
    tick();
    idle_inputs();
    check("blink_chg_old", 64'(digit_of(final_disp, 0)), 64'h7F);
    tick();
    check("blink_chg_new", 64'(digit_of(final_disp, 0)), 64'h20);
    repeat (5) tick();
`else
    mode_load = 1'b1; mode_in = 2'd2;
    tick();
    idle_inputs();
    repeat (3) tick();
`endif

    // 6: reset while at mode 2
    check("pre_rst_mode", 64'(mode), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_mode", 64'(mode), 64'd0);
    check("rst2_disp", 64'(final_disp), 64'(blank_all));
    tick();
    check("rst2_d0", 64'(digit_of(final_disp, 0)), 64'h00);
    blink_mask = '0;

    // random phase, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      mode_btn  = ($urandom_range(0, 3) == 0);
      mode_load = ($urandom_range(0, 7) == 0);
      mode_in   = MW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) src_valid = NS'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) blink_mask = ND'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        src_val[$urandom_range(0, NS-1)][$urandom_range(0, ND-1)] = SW'($urandom);
        pack_src();
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
